// File: rtl/nios2_pio_out_pulse.sv
// nios2_pio_out_pulse
// Avalon-MM output PIO for the Nios II. The CPU drives out_port through
// direct-write, bit-set and bit-clear registers. A pulse engine can raise
// selected bits for a programmed number of clocks and then drop them again
// without any further CPU involvement.
module nios2_pio_out_pulse #(
    parameter int DATA_WIDTH      = 8,
    parameter int RESET_VALUE     = 0,
    parameter int CNT_WIDTH       = 16,
    parameter int PULSE_LEN_RESET = 100
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  pulse_busy
);

    localparam logic [DATA_WIDTH-1:0] OUT_RESET = DATA_WIDTH'(RESET_VALUE);
    localparam logic [CNT_WIDTH-1:0]  LEN_RESET = CNT_WIDTH'(PULSE_LEN_RESET);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_OUTSET    = 3'd1;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd2;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
    localparam logic [2:0] ADDR_PULSE     = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    // Architectural state
    logic [DATA_WIDTH-1:0] pulse_mask;
    logic [CNT_WIDTH-1:0]  counter;
    logic [CNT_WIDTH-1:0]  pulse_len;

    // Next-state values
    logic [DATA_WIDTH-1:0] out_next;
    logic [DATA_WIDTH-1:0] mask_next;
    logic [CNT_WIDTH-1:0]  counter_next;
    logic [CNT_WIDTH-1:0]  len_next;
    logic [31:0]           read_next;

    logic                  bus_write;
    logic                  expiring;
    logic [DATA_WIDTH-1:0] write_bits;
    logic                  unused_bits;

    assign bus_write   = chipselect && !write_n;
    assign write_bits  = writedata[DATA_WIDTH-1:0];
    assign expiring    = (counter == CNT_ONE);
    assign pulse_busy  = (counter != '0);

    // Not every writedata bit lands in a register for narrow configurations.
    assign unused_bits = ^writedata;

    // Next-state logic: the pulse engine's expiry/countdown is resolved
    // first, then any bus write is layered on top so a write at the expiry
    // edge always sees the post-expiry state.
    always_comb begin
        out_next     = out_port;
        mask_next    = pulse_mask;
        counter_next = counter;
        len_next     = pulse_len;

        if (expiring) begin
            out_next     = out_port & ~pulse_mask;
            mask_next    = '0;
            counter_next = '0;
        end else if (pulse_busy) begin
            counter_next = counter - CNT_ONE;
        end

        if (bus_write) begin
            case (address)
                ADDR_DATA: begin
                    out_next = write_bits;
                end
                ADDR_OUTSET: begin
                    out_next = out_next | write_bits;
                end
                ADDR_OUTCLEAR: begin
                    out_next  = out_next & ~write_bits;
                    mask_next = mask_next & ~write_bits;
                end
                ADDR_PULSE_LEN: begin
                    len_next = writedata[CNT_WIDTH-1:0];
                end
                ADDR_PULSE: begin
                    if ((pulse_len != '0) && (write_bits != '0)) begin
                        out_next     = out_next | write_bits;
                        mask_next    = mask_next | write_bits;
                        counter_next = pulse_len;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read mux: zero-extended view of the addressed register, captured every
    // clock so readdata trails address by one cycle with no read strobe.
    always_comb begin
        read_next = '0;
        case (address)
            ADDR_DATA:      read_next = 32'(out_port);
            ADDR_PULSE_LEN: read_next = 32'(pulse_len);
            ADDR_STATUS:    read_next = (32'(pulse_mask) << 8) | 32'(pulse_busy);
            default:        read_next = '0;
        endcase
    end

    // Register update with asynchronous active-low reset; reset also aborts
    // any pulse in flight by clearing the mask and the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port   <= OUT_RESET;
            pulse_mask <= '0;
            counter    <= '0;
            pulse_len  <= LEN_RESET;
            readdata   <= '0;
        end else begin
            out_port   <= out_next;
            pulse_mask <= mask_next;
            counter    <= counter_next;
            pulse_len  <= len_next;
            readdata   <= read_next;
        end
    end

endmodule

// File: tb/tb_nios2_pio_out_pulse.sv
// Testbench for nios2_pio_out_pulse. The reference model keeps the pulse as an
// absolute expiry time (the cycle number at which the masked bits drop)
// instead of a down-counter, and every cycle checks out_port, pulse_busy and
// readdata against it. Directed steps walk through the interesting cases,
// then a randomized phase mixes arbitrary bus traffic.
module tb_nios2_pio_out_pulse;

    localparam int DW = 8;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [DW-1:0] out_port;
    logic        pulse_busy;

    int tests;
    int failures;

    // Reference model state
    logic [DW-1:0] m_out;
    logic [DW-1:0] m_mask;
    int            m_len;
    int            m_expiry;
    int            cyc;
    logic [31:0]   exp_read;

    nios2_pio_out_pulse dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_busy (pulse_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic modelBusy();
        return m_expiry >= 0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [2:0] addr);
        case (addr)
            3'd0:    return {24'd0, m_out};
            3'd3:    return 32'(m_len);
            3'd5:    return {16'd0, m_mask, 7'd0, modelBusy()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic modelReset();
        m_out    = '0;
        m_mask   = '0;
        m_len    = 100;
        m_expiry = -1;
    endtask

    task automatic modelEdge(input logic wr, input logic [2:0] addr, input logic [31:0] wd);
        cyc++;
        if (m_expiry == cyc) begin
            m_out    = m_out & ~m_mask;
            m_mask   = '0;
            m_expiry = -1;
        end
        if (wr) begin
            case (addr)
                3'd0: m_out = wd[DW-1:0];
                3'd1: m_out = m_out | wd[DW-1:0];
                3'd2: begin
                    m_out  = m_out & ~wd[DW-1:0];
                    m_mask = m_mask & ~wd[DW-1:0];
                end
                3'd3: m_len = int'(wd[15:0]);
                3'd4: begin
                    if (m_len != 0 && wd[DW-1:0] != '0) begin
                        m_out    = m_out | wd[DW-1:0];
                        m_mask   = m_mask | wd[DW-1:0];
                        m_expiry = cyc + m_len;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // One bus cycle: drive at the falling edge, advance the model at the
    // rising edge, then check every output shortly after it.
    task automatic applyStimulus(input logic cs, input logic wn, input logic [2:0] addr, input logic [31:0] wd);
        @(negedge clk);
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = wd;
        exp_read   = modelRead(addr);
        @(posedge clk);
        modelEdge(cs && !wn, addr, wd);
        #1;
        checkOutput("out_port", 32'(out_port), 32'(m_out));
        checkOutput("pulse_busy", 32'(pulse_busy), 32'(modelBusy()));
        checkOutput("readdata", readdata, exp_read);
    endtask

    task automatic busWrite(input logic [2:0] addr, input logic [31:0] wd);
        applyStimulus(1'b1, 1'b0, addr, wd);
    endtask

    task automatic idle(input logic [2:0] addr);
        applyStimulus(1'b0, 1'b1, addr, $urandom);
    endtask

    initial begin
        tests      = 0;
        failures   = 0;
        cyc        = 0;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        modelReset();

        // Power-on reset
        #12;
        checkOutput("reset_out", 32'(out_port), 32'h0);
        checkOutput("reset_busy", 32'(pulse_busy), 32'h0);
        checkOutput("reset_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // DATA / OUTSET / OUTCLEAR and readback
        busWrite(3'd0, 32'hFFFF_FFA5);
        checkOutput("data_a5", 32'(out_port), 32'hA5);
        busWrite(3'd1, 32'h0F);
        checkOutput("outset_af", 32'(out_port), 32'hAF);
        busWrite(3'd2, 32'h81);
        checkOutput("outclear_2e", 32'(out_port), 32'h2E);
        idle(3'd0);
        checkOutput("read_data_2e", readdata, 32'h0000_002E);
        idle(3'd1);
        checkOutput("read_addr1", readdata, 32'h0);
        idle(3'd2);
        idle(3'd4);
        idle(3'd6);
        checkOutput("read_addr6", readdata, 32'h0);
        // Chipselect low with write_n low is not a write
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h55);
        checkOutput("no_cs_write", 32'(out_port), 32'h2E);

        // Basic pulse, L=5
        busWrite(3'd0, 32'h00);
        busWrite(3'd3, 32'd5);
        busWrite(3'd4, 32'h03);
        checkOutput("pulse_start", 32'(out_port), 32'h03);
        for (int i = 1; i <= 5; i++) begin
            idle(3'd5);
            checkOutput("pulse_out", 32'(out_port), (i < 5) ? 32'h03 : 32'h00);
            checkOutput("pulse_status", readdata, 32'h0000_0301);
        end
        idle(3'd5);
        checkOutput("pulse_done_status", readdata, 32'h0);

        // Retrigger, L=4
        busWrite(3'd3, 32'd4);
        busWrite(3'd4, 32'h01);
        idle(3'd5);
        busWrite(3'd4, 32'h02);
        for (int i = 0; i < 3; i++) begin
            idle(3'd5);
            checkOutput("retrig_hold", 32'(out_port), 32'h03);
        end
        idle(3'd0);
        checkOutput("retrig_clear", 32'(out_port), 32'h00);
        busWrite(3'd3, 32'd0);
        busWrite(3'd4, 32'hFF);
        checkOutput("len0_noeffect", 32'(out_port), 32'h00);

        // Collision at expiry: DATA wins
        busWrite(3'd3, 32'd3);
        busWrite(3'd4, 32'h10);
        idle(3'd5);
        idle(3'd5);
        busWrite(3'd0, 32'h11);
        checkOutput("collide_data", 32'(out_port), 32'h11);
        idle(3'd5);
        checkOutput("collide_status", readdata, 32'h0);
        // Collision at expiry: new pulse restarts
        busWrite(3'd0, 32'h00);
        busWrite(3'd4, 32'h10);
        idle(3'd5);
        idle(3'd5);
        busWrite(3'd4, 32'h10);
        checkOutput("collide_pulse", 32'(out_port), 32'h10);
        idle(3'd5);
        idle(3'd5);
        checkOutput("collide_pulse_hold", 32'(out_port), 32'h10);
        idle(3'd5);
        checkOutput("collide_pulse_end", 32'(out_port), 32'h00);

        // OUTCLEAR during a pulse, L=10
        busWrite(3'd3, 32'd10);
        busWrite(3'd4, 32'h0C);
        idle(3'd5);
        busWrite(3'd2, 32'h04);
        checkOutput("outclear_mid", 32'(out_port), 32'h08);
        idle(3'd5);
        checkOutput("outclear_status", readdata, 32'h0000_0801);
        for (int i = 4; i <= 10; i++) idle(3'd5);
        checkOutput("outclear_expire", 32'(out_port), 32'h00);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            int          r;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd3) d = 32'($urandom_range(0, 8));
            r = $urandom_range(0, 9);
            if (r < 4)      applyStimulus(1'b1, 1'b0, a, d);
            else if (r < 5) applyStimulus(1'b1, 1'b0, 3'd4, $urandom);
            else if (r < 6) applyStimulus(1'b0, 1'b0, a, d);
            else if (r < 7) applyStimulus(1'b1, 1'b1, a, d);
            else            idle(a);
        end

        // Reset in the middle of a pulse
        busWrite(3'd3, 32'd20);
        busWrite(3'd4, 32'hFF);
        idle(3'd5);
        #2;
        reset_n = 1'b0;
        modelReset();
        #2;
        checkOutput("midreset_out", 32'(out_port), 32'h0);
        checkOutput("midreset_busy", 32'(pulse_busy), 32'h0);
        checkOutput("midreset_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3'd5);
        checkOutput("midreset_status", readdata, 32'h0);
        idle(3'd3);
        checkOutput("midreset_len", readdata, 32'd100);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
